// File: rtl/riscv_m_pkg.sv
// rtl/riscv_m_pkg.sv - shared types for the iterative RV64M multiply/divide unit
package riscv_m_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    localparam int WORD_W = 32;

endpackage

// File: rtl/mul_div_iter.sv
// rtl/mul_div_iter.sv - iterative RV64M multiply/divide with fixed latency and start/busy/done handshake
module mul_div_iter
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   opnd_q;
    logic              is_div_q, word_q, sel_hi_q, neg_q, div_zero_q;

    function automatic logic [XLEN-1:0] sext32(input logic [WORD_W-1:0] v);
        logic [XLEN-1:0] t;
        t = {XLEN{v[WORD_W-1]}};
        t[WORD_W-1:0] = v;
        return t;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [WORD_W-1:0] v);
        logic [XLEN-1:0] t;
        t = '0;
        t[WORD_W-1:0] = v;
        return t;
    endfunction

    // Operand preparation for the accepting edge: magnitudes plus recorded result signs.
    logic            word_eff, is_div, a_sgn_op, b_sgn_op, sa, sb, sel_hi, neg, accept;
    logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, div_lo;
    logic [CW-1:0]   cnt_init;

    always_comb begin
        word_eff = (XLEN == 64) ? word : 1'b0;
        is_div   = op[2];
        a_sgn_op = is_div ? ~op[0] : ((op == OP_MULH || op == OP_MULHSU) && !word_eff);
        b_sgn_op = is_div ? ~op[0] : ((op == OP_MULH) && !word_eff);
        a_ext    = word_eff ? (a_sgn_op ? sext32(a[WORD_W-1:0]) : zext32(a[WORD_W-1:0])) : a;
        b_ext    = word_eff ? (b_sgn_op ? sext32(b[WORD_W-1:0]) : zext32(b[WORD_W-1:0])) : b;
        sa       = a_sgn_op & a_ext[XLEN-1];
        sb       = b_sgn_op & b_ext[XLEN-1];
        abs_a    = sa ? -a_ext : a_ext;
        abs_b    = sb ? -b_ext : b_ext;
        sel_hi   = is_div ? op[1] : ((op[1:0] != 2'b00) && !word_eff);
        neg      = is_div ? (op[1] ? sa : (sa ^ sb)) : (sel_hi & (sa ^ sb));
        // Word dividends sit in the top half so 32 steps consume exactly their bits.
        div_lo   = word_eff ? (abs_a << (XLEN - WORD_W)) : abs_a;
        cnt_init = word_eff ? CW'(WORD_W) : CW'(XLEN);
        accept   = (state_q == IDLE) && start && !flush;
    end

    // One shared adder: shift-add for multiply, restoring trial subtract for divide.
    logic [XLEN-1:0]   hi, lo;
    logic [XLEN+1:0]   add_x, add_y, sum;
    logic [2*XLEN-1:0] prod_step;

    always_comb begin
        hi    = prod_q[2*XLEN-1:XLEN];
        lo    = prod_q[XLEN-1:0];
        add_x = is_div_q ? {1'b0, hi, lo[XLEN-1]} : {2'b00, hi};
        add_y = is_div_q ? ~{2'b00, opnd_q} : {2'b00, (prod_q[0] ? opnd_q : {XLEN{1'b0}})};
        sum   = add_x + add_y + {{(XLEN+1){1'b0}}, is_div_q};
        if (is_div_q) begin
            if (!sum[XLEN+1]) prod_step = {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
            else              prod_step = {hi[XLEN-2:0], lo, 1'b0};
        end else begin
            prod_step = {sum[XLEN:0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   mul_res, quot, rem, div_pick, fix_res;

    always_comb begin
        mul_full = neg_q ? -prod_q : prod_q;
        mul_res  = word_q ? sext32(prod_q[XLEN-1 -: WORD_W])
                          : (sel_hi_q ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0]);
        quot     = div_zero_q ? {XLEN{1'b1}} : (neg_q ? -lo : lo);
        rem      = neg_q ? -hi : hi;
        div_pick = sel_hi_q ? rem : quot;
        fix_res  = is_div_q ? (word_q ? sext32(div_pick[WORD_W-1:0]) : div_pick) : mul_res;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: if (cnt_q == CW'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
        busy = (state_q == CALC) || (state_q == FIX);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            prod_q     <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            word_q     <= 1'b0;
            sel_hi_q   <= 1'b0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            result     <= '0;
        end else if (accept) begin
            cnt_q      <= cnt_init;
            prod_q     <= {{XLEN{1'b0}}, (is_div ? div_lo : abs_a)};
            opnd_q     <= abs_b;
            is_div_q   <= is_div;
            word_q     <= word_eff;
            sel_hi_q   <= sel_hi;
            neg_q      <= neg;
            div_zero_q <= (b_ext == '0);
        end else if (!flush && state_q == CALC) begin
            cnt_q  <= cnt_q - CW'(1);
            prod_q <= prod_step;
        end else if (!flush && state_q == FIX) begin
            result <= fix_res;
        end
    end

endmodule

// File: tb/tb_mul_div_iter.sv
// tb/tb_mul_div_iter.sv - directed self-checking bench for mul_div_iter
module tb_mul_div_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        word = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy, done;
    logic [63:0] result;

    int n_vec = 0;
    int n_err = 0;

    mul_div_iter #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op), .word(word),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                          output logic [63:0] r, output int lat, output int bc);
        @(negedge clk);
        op = o; word = w; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; op = ~o;
        lat = -1; bc = 0; r = '0;
        for (int c = 1; c <= 200; c++) begin
            if (busy) bc++;
            if (done) begin
                lat = c; r = result;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic vec(input string name, input logic [2:0] o, input logic w, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] exp_r, input int exp_lat);
        logic [63:0] r;
        int lat, bc;
        run_op(o, w, x, y, r, lat, bc);
        n_vec++;
        if (r !== exp_r || lat != exp_lat) begin
            n_err++;
            $display("FAIL %s: result=%h lat=%0d, expected result=%h lat=%0d", name, r, lat, exp_r, exp_lat);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, expected 0 0 0", busy, done, result);
        end
        reset = 1'b1;
    endtask

    task automatic test_mul;
        logic [63:0] r;
        int lat, bc;
        run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, lat, bc);
        n_vec++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFEB || lat != 66 || bc != 65) begin
            n_err++;
            $display("FAIL mul_7x-3: result=%h lat=%0d busy=%0d, expected FFFFFFFFFFFFFFEB 66 65", r, lat, bc);
        end
        vec("mul_big", 3'd0, 1'b0, 64'h0000_0001_0000_0001, 64'h0000_0000_0000_0003, 64'h0000_0003_0000_0003, 66);
    endtask

    task automatic test_mulh;
        vec("mulhu_ones", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        vec("mulh_m1_m1", 3'd1, 1'b0, '1, '1, 64'd0, 66);
        vec("mulhsu_m1_2", 3'd2, 1'b0, '1, 64'd2, '1, 66);
        vec("mulh_pos", 3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd8, 64'd2, 66);
    endtask

    task automatic test_div;
        vec("div_m7_2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        vec("rem_m7_2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 66);
        vec("divu_5_0", 3'd5, 1'b0, 64'd5, 64'd0, '1, 66);
        vec("remu_5_0", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 66);
        vec("div_m5_0", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, '1, 66);
        vec("rem_m5_0", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 66);
        vec("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        vec("remu_100_7", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    endtask

    task automatic test_overflow;
        vec("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 66);
        vec("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 66);
        vec("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 34);
    endtask

    task automatic test_word;
        vec("mulw", 3'd0, 1'b1, 64'h0000_0001_0000_0003, 64'd2, 64'd6, 34);
        vec("mulw_neg", 3'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        vec("mulhw_as_mulw", 3'd1, 1'b1, 64'h0000_0001_0000_0003, 64'd2, 64'd6, 34);
        vec("divuw_ones", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, '1, 34);
        vec("remw_m7_2", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 34);
    endtask

    task automatic test_flush;
        logic [63:0] prior;
        logic        saw_done;
        prior = result;
        @(negedge clk);
        op = 3'd5; word = 1'b0; a = 64'd100; b = 64'd7; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_with_start: busy=%b, expected 0", busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (saw_done !== 1'b0 || result !== prior) begin
            n_err++;
            $display("FAIL flush_no_done: done_seen=%b result=%h, expected 0 %h", saw_done, result, prior);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        op = 3'd0; word = 1'b0; a = 64'd9; b = 64'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h, expected 0 0 0", busy, done, result);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] r;
        int lat, bc;
        @(negedge clk);
        op = 3'd5; word = 1'b0; a = 64'd100; b = 64'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'd0; a = 64'd1000; b = 64'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; r = '0;
        for (int c = 6; c <= 200; c++) begin
            if (done) begin
                lat = c; r = result;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (r !== 64'd14 || lat != 66) begin
            n_err++;
            $display("FAIL start_while_busy: result=%h lat=%0d, expected 14 66", r, lat);
        end
        start = 1'b1; op = 3'd0; a = 64'd3; b = 64'd3;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done: busy=%b done=%b, expected 0 0", busy, done);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done_idle: busy=%b, expected 0", busy);
        end
        vec("after_done", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 66);
        vec("next_back", 3'd6, 1'b0, 64'd17, 64'd5, 64'd2, 66);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_overflow();
        test_word();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
